// File: rtl/scoreboard_register_file_pkg.sv
// rtl/scoreboard_register_file_pkg.sv - shared sizes and types for the scoreboarded register file
// Default geometry plus the write-back request layout used by issue/write-back logic.
package register_file_params;

  localparam int REGISTER_SIZE             = 32;
  localparam int REGISTER_DESCRIPTOR_WIDTH = $clog2(REGISTER_SIZE);
  localparam int OPERAND_WIDTH             = 32;
  localparam int TAG_WIDTH                 = 4;
  localparam int NUM_READ_PORTS            = 2;
  localparam int NUM_WB_PORTS              = 2;

  typedef logic [REGISTER_DESCRIPTOR_WIDTH-1:0] reg_idx_t;
  typedef logic [TAG_WIDTH-1:0]                 tag_t;
  typedef logic [OPERAND_WIDTH-1:0]             operand_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t idx;
    tag_t     tag;
    operand_t data;
  } wb_req_t;

endpackage

// File: rtl/scoreboard_register_file_cell.sv
// rtl/scoreboard_register_file_cell.sv - one architectural register: data, busy flag, producer tag
// Write-enable and tag-match decisions are resolved by the parent; this cell only applies priority.
module scoreboard_register_cell
  import register_file_params::*;
#(
  parameter int CELL_WIDTH     = OPERAND_WIDTH,
  parameter int CELL_TAG_WIDTH = TAG_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      wr_en,
  input  logic [CELL_WIDTH-1:0]     wr_data,
  input  logic                      tag_clear,
  input  logic                      reserve,
  input  logic [CELL_TAG_WIDTH-1:0] reserve_tag,
  output logic [CELL_WIDTH-1:0]     data,
  output logic                      busy,
  output logic [CELL_TAG_WIDTH-1:0] tag
);

  logic [CELL_WIDTH-1:0]     data_q, data_d;
  logic                      busy_q, busy_d;
  logic [CELL_TAG_WIDTH-1:0] tag_q, tag_d;

  // flush beats reserve, reserve beats a matching write-back clear
  always_comb begin
    data_d = wr_en ? wr_data : data_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (flush) begin
      busy_d = 1'b0;
    end else if (reserve) begin
      busy_d = 1'b1;
      tag_d  = reserve_tag;
    end else if (tag_clear) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      busy_q <= 1'b0;
      tag_q  <= '0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  assign data = data_q;
  assign busy = busy_q;
  assign tag  = tag_q;

endmodule

// File: rtl/scoreboard_register_file.sv
// rtl/scoreboard_register_file.sv - multi-port register file with tagged scoreboard and write-back bypass
// Register 0 is hardwired zero; indices at or above REGISTER_SIZE are ignored and read as zero.
module scoreboard_register_file #(
  parameter int NUM_READ_PORTS = register_file_params::NUM_READ_PORTS,
  parameter int NUM_WB_PORTS   = register_file_params::NUM_WB_PORTS,
  parameter int REGISTER_SIZE  = register_file_params::REGISTER_SIZE,
  parameter int OPERAND_WIDTH  = register_file_params::OPERAND_WIDTH,
  parameter int TAG_WIDTH      = register_file_params::TAG_WIDTH,
  localparam int RDW           = (REGISTER_SIZE > 1) ? $clog2(REGISTER_SIZE) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flush_input,
  input  logic [NUM_READ_PORTS*RDW-1:0]           read_reg_input,
  output logic [NUM_READ_PORTS*OPERAND_WIDTH-1:0] read_data_output,
  output logic [NUM_READ_PORTS-1:0]               read_busy_output,
  output logic [NUM_READ_PORTS*TAG_WIDTH-1:0]     read_tag_output,
  input  logic                                    reserve_input,
  input  logic [RDW-1:0]                          reserve_reg_input,
  input  logic [TAG_WIDTH-1:0]                    reserve_tag_input,
  input  logic [NUM_WB_PORTS-1:0]                 wb_valid_input,
  input  logic [NUM_WB_PORTS*RDW-1:0]             wb_reg_input,
  input  logic [NUM_WB_PORTS*TAG_WIDTH-1:0]       wb_tag_input,
  input  logic [NUM_WB_PORTS*OPERAND_WIDTH-1:0]   wb_data_input
);

  logic [OPERAND_WIDTH-1:0] cell_data [REGISTER_SIZE];
  logic                     cell_busy [REGISTER_SIZE];
  logic [TAG_WIDTH-1:0]     cell_tag  [REGISTER_SIZE];

  assign cell_data[0] = '0;
  assign cell_busy[0] = 1'b0;
  assign cell_tag[0]  = '0;

  for (genvar r = 1; r < REGISTER_SIZE; r++) begin : g_reg
    logic                     wr_en;
    logic [OPERAND_WIDTH-1:0] wr_data;
    logic [TAG_WIDTH-1:0]     wr_tag;
    logic                     tag_clear;
    logic                     reserve;

    // ascending scan: the highest-indexed hitting port supplies data and the tag to compare
    always_comb begin
      wr_en   = 1'b0;
      wr_data = '0;
      wr_tag  = '0;
      for (int p = 0; p < NUM_WB_PORTS; p++) begin
        if (wb_valid_input[p] && (wb_reg_input[p*RDW +: RDW] == RDW'(r))) begin
          wr_en   = 1'b1;
          wr_data = wb_data_input[p*OPERAND_WIDTH +: OPERAND_WIDTH];
          wr_tag  = wb_tag_input[p*TAG_WIDTH +: TAG_WIDTH];
        end
      end
    end

    assign tag_clear = wr_en && (wr_tag == cell_tag[r]);
    assign reserve   = reserve_input && (reserve_reg_input == RDW'(r));

    scoreboard_register_cell #(
      .CELL_WIDTH     (OPERAND_WIDTH),
      .CELL_TAG_WIDTH (TAG_WIDTH)
    ) u_cell (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush_input),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .tag_clear   (tag_clear),
      .reserve     (reserve),
      .reserve_tag (reserve_tag_input),
      .data        (cell_data[r]),
      .busy        (cell_busy[r]),
      .tag         (cell_tag[r])
    );
  end

  // read mux; a same-cycle write-back forwards its data and may retire the pending producer
  always_comb begin
    logic [RDW-1:0]           idx;
    logic [OPERAND_WIDTH-1:0] rd_data;
    logic                     rd_busy;
    logic [TAG_WIDTH-1:0]     rd_tag;
    read_data_output = '0;
    read_busy_output = '0;
    read_tag_output  = '0;
    for (int k = 0; k < NUM_READ_PORTS; k++) begin
      idx     = read_reg_input[k*RDW +: RDW];
      rd_data = '0;
      rd_busy = 1'b0;
      rd_tag  = '0;
      if ((idx != '0) && (int'(idx) < REGISTER_SIZE)) begin
        rd_data = cell_data[idx];
        rd_busy = cell_busy[idx];
        rd_tag  = cell_tag[idx];
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
          if (wb_valid_input[p] && (wb_reg_input[p*RDW +: RDW] == idx)) begin
            rd_data = wb_data_input[p*OPERAND_WIDTH +: OPERAND_WIDTH];
            rd_busy = cell_busy[idx] &&
                      (wb_tag_input[p*TAG_WIDTH +: TAG_WIDTH] != cell_tag[idx]);
          end
        end
      end
      read_data_output[k*OPERAND_WIDTH +: OPERAND_WIDTH] = rd_data;
      read_busy_output[k]                                = rd_busy;
      read_tag_output[k*TAG_WIDTH +: TAG_WIDTH]          = rd_tag;
    end
  end

endmodule

// File: tb/tb_scoreboard_register_file.sv
// tb/tb_scoreboard_register_file.sv - directed scenarios plus random traffic against a scoreboard model
module tb_scoreboard_register_file;

  localparam int NR = 2;
  localparam int NW = 2;
  localparam int RS = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic [4:0]  rd_idx [NR];
  logic        rsv = 1'b0;
  logic [4:0]  rsv_reg = '0;
  logic [3:0]  rsv_tag = '0;
  logic        wb_v [NW];
  logic [4:0]  wb_r [NW];
  logic [3:0]  wb_t [NW];
  logic [31:0] wb_d [NW];

  logic [NR*5-1:0]  read_reg_input;
  logic [NR*32-1:0] read_data_output;
  logic [NR-1:0]    read_busy_output;
  logic [NR*4-1:0]  read_tag_output;

  logic [31:0] m_data [RS];
  logic        m_busy [RS];
  logic [3:0]  m_tag  [RS];
  logic [31:0] n_data [RS];
  logic        n_busy [RS];
  logic [3:0]  n_tag  [RS];

  int n_vec = 0;
  int n_err = 0;

  assign read_reg_input = {rd_idx[1], rd_idx[0]};

  always #5 clk = ~clk;

  scoreboard_register_file dut (
    .clk               (clk),
    .rst               (rst),
    .flush_input       (flush),
    .read_reg_input    (read_reg_input),
    .read_data_output  (read_data_output),
    .read_busy_output  (read_busy_output),
    .read_tag_output   (read_tag_output),
    .reserve_input     (rsv),
    .reserve_reg_input (rsv_reg),
    .reserve_tag_input (rsv_tag),
    .wb_valid_input    ({wb_v[1], wb_v[0]}),
    .wb_reg_input      ({wb_r[1], wb_r[0]}),
    .wb_tag_input      ({wb_t[1], wb_t[0]}),
    .wb_data_input     ({wb_d[1], wb_d[0]})
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic idle();
    flush = 1'b0;
    rsv   = 1'b0;
    rsv_reg = '0;
    rsv_tag = '0;
    for (int p = 0; p < NW; p++) begin
      wb_v[p] = 1'b0; wb_r[p] = '0; wb_t[p] = '0; wb_d[p] = '0;
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < RS; r++) begin
      m_data[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
    end
  endtask

  // expected read: stored state, overridden by the last matching write-back this cycle
  task automatic model_read(input int idx, output logic [31:0] d, output logic b, output logic [3:0] t);
    d = '0; b = 1'b0; t = '0;
    if (idx != 0) begin
      d = m_data[idx]; b = m_busy[idx]; t = m_tag[idx];
      for (int p = 0; p < NW; p++)
        if (wb_v[p] && int'(wb_r[p]) == idx) begin
          d = wb_d[p];
          b = m_busy[idx] && (wb_t[p] != m_tag[idx]);
        end
    end
  endtask

  task automatic model_next();
    int last [RS];
    for (int r = 0; r < RS; r++) begin
      n_data[r] = m_data[r]; n_busy[r] = m_busy[r]; n_tag[r] = m_tag[r]; last[r] = -1;
    end
    for (int p = 0; p < NW; p++)
      if (wb_v[p]) last[wb_r[p]] = p;
    for (int r = 1; r < RS; r++)
      if (last[r] >= 0) begin
        n_data[r] = wb_d[last[r]];
        if (wb_t[last[r]] == m_tag[r]) n_busy[r] = 1'b0;
      end
    if (rsv && rsv_reg != 0 && !flush) begin
      n_busy[rsv_reg] = 1'b1;
      n_tag[rsv_reg]  = rsv_tag;
    end
    if (flush)
      for (int r = 0; r < RS; r++) n_busy[r] = 1'b0;
  endtask

  task automatic check_reads(input string ctx);
    logic [31:0] ed;
    logic        eb;
    logic [3:0]  et;
    for (int k = 0; k < NR; k++) begin
      model_read(int'(rd_idx[k]), ed, eb, et);
      check_eq({ctx, "_data"}, 64'(read_data_output[k*32 +: 32]), 64'(ed));
      if (!flush) begin
        check_eq({ctx, "_busy"}, 64'(read_busy_output[k]), 64'(eb));
        if (eb) check_eq({ctx, "_tag"}, 64'(read_tag_output[k*4 +: 4]), 64'(et));
      end
    end
  endtask

  task automatic run_cycle(input string ctx);
    #1;
    check_reads(ctx);
    model_next();
    @(posedge clk);
    for (int r = 0; r < RS; r++) begin
      m_data[r] = n_data[r]; m_busy[r] = n_busy[r]; m_tag[r] = n_tag[r];
    end
    @(negedge clk);
  endtask

  task automatic expect_port(input string tag, input int k, input logic [31:0] d, input logic b);
    check_eq({tag, "_d"}, 64'(read_data_output[k*32 +: 32]), 64'(d));
    check_eq({tag, "_b"}, 64'(read_busy_output[k]), 64'(b));
  endtask

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 3) != 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, RS - 1));
  endfunction

  task automatic random_inputs();
    for (int k = 0; k < NR; k++) rd_idx[k] = pick_reg();
    rsv     = ($urandom_range(0, 2) == 0);
    rsv_reg = pick_reg();
    rsv_tag = 4'($urandom);
    for (int p = 0; p < NW; p++) begin
      wb_v[p] = ($urandom_range(0, 1) == 1);
      wb_r[p] = pick_reg();
      wb_t[p] = ($urandom_range(0, 1) == 1) ? m_tag[wb_r[p]] : 4'($urandom);
      wb_d[p] = $urandom;
    end
    flush = ($urandom_range(0, 31) == 0);
  endtask

  initial begin
    idle();
    rd_idx[0] = 5'd1; rd_idx[1] = 5'd5;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    expect_port("rst_r1", 0, 32'h0, 1'b0);
    expect_port("rst_r5", 1, 32'h0, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // 1: plain write-back without reservation
    wb_v[0] = 1'b1; wb_r[0] = 5'd5; wb_t[0] = 4'd0; wb_d[0] = 32'h1234;
    run_cycle("t1");
    idle();
    #1 expect_port("t1_r5", 1, 32'h1234, 1'b0);

    // 2: reserve then matching write-back with same-cycle bypass
    rsv = 1'b1; rsv_reg = 5'd3; rsv_tag = 4'd2;
    run_cycle("t2a");
    idle();
    rd_idx[0] = 5'd3;
    #1 expect_port("t2_rsv", 0, 32'h0, 1'b1);
    check_eq("t2_tag", 64'(read_tag_output[3:0]), 64'd2);
    wb_v[0] = 1'b1; wb_r[0] = 5'd3; wb_t[0] = 4'd2; wb_d[0] = 32'hAA;
    #1 expect_port("t2_byp", 0, 32'hAA, 1'b0);
    run_cycle("t2b");
    idle();
    #1 expect_port("t2_done", 0, 32'hAA, 1'b0);

    // 3: stale write-back must not clear a newer reservation
    rsv = 1'b1; rsv_reg = 5'd4; rsv_tag = 4'd1;
    run_cycle("t3a");
    rsv_tag = 4'd7;
    run_cycle("t3b");
    idle();
    wb_v[0] = 1'b1; wb_r[0] = 5'd4; wb_t[0] = 4'd1; wb_d[0] = 32'h11;
    run_cycle("t3c");
    idle();
    rd_idx[0] = 5'd4;
    #1 expect_port("t3_stale", 0, 32'h11, 1'b1);
    check_eq("t3_tag", 64'(read_tag_output[3:0]), 64'd7);
    wb_v[0] = 1'b1; wb_r[0] = 5'd4; wb_t[0] = 4'd7; wb_d[0] = 32'h77;
    run_cycle("t3d");
    idle();
    #1 expect_port("t3_clear", 0, 32'h77, 1'b0);

    // 4: two write-backs to one register, then reserve racing a write-back
    rsv = 1'b1; rsv_reg = 5'd6; rsv_tag = 4'd3;
    run_cycle("t4a");
    idle();
    wb_v[0] = 1'b1; wb_r[0] = 5'd6; wb_t[0] = 4'd3; wb_d[0] = 32'h1;
    wb_v[1] = 1'b1; wb_r[1] = 5'd6; wb_t[1] = 4'd3; wb_d[1] = 32'h2;
    run_cycle("t4b");
    idle();
    rd_idx[0] = 5'd6;
    #1 expect_port("t4_dual", 0, 32'h2, 1'b0);
    rsv = 1'b1; rsv_reg = 5'd6; rsv_tag = 4'd5;
    wb_v[0] = 1'b1; wb_r[0] = 5'd6; wb_t[0] = 4'd3; wb_d[0] = 32'h3;
    run_cycle("t4c");
    idle();
    #1 expect_port("t4_rsvwin", 0, 32'h3, 1'b1);
    check_eq("t4_tag", 64'(read_tag_output[3:0]), 64'd5);

    // 5: flush drops reservations, keeps write-back, ignores reserve
    rsv = 1'b1; rsv_tag = 4'd4;
    rsv_reg = 5'd1; run_cycle("t5a");
    rsv_reg = 5'd2; run_cycle("t5b");
    rsv_reg = 5'd9; run_cycle("t5c");
    idle();
    flush = 1'b1; rsv = 1'b1; rsv_reg = 5'd10; rsv_tag = 4'd1;
    wb_v[0] = 1'b1; wb_r[0] = 5'd2; wb_t[0] = 4'd0; wb_d[0] = 32'h55;
    run_cycle("t5d");
    idle();
    rd_idx[0] = 5'd1; rd_idx[1] = 5'd2;
    #1 expect_port("t5_r1", 0, 32'h0, 1'b0);
    expect_port("t5_r2", 1, 32'h55, 1'b0);
    rd_idx[0] = 5'd9; rd_idx[1] = 5'd10;
    #1 check_eq("t5_r9_b", 64'(read_busy_output[0]), 64'd0);
    check_eq("t5_r10_b", 64'(read_busy_output[1]), 64'd0);

    // 6: register 0 is immutable; async reset wipes a pending reservation
    rsv = 1'b1; rsv_reg = 5'd0; rsv_tag = 4'd3;
    wb_v[1] = 1'b1; wb_r[1] = 5'd0; wb_t[1] = 4'd0; wb_d[1] = 32'hFFFF;
    rd_idx[0] = 5'd0;
    #1 expect_port("t6_r0_byp", 0, 32'h0, 1'b0);
    run_cycle("t6a");
    idle();
    #1 expect_port("t6_r0", 0, 32'h0, 1'b0);
    check_eq("t6_r0_tag", 64'(read_tag_output[3:0]), 64'd0);
    rsv = 1'b1; rsv_reg = 5'd7; rsv_tag = 4'd9;
    wb_v[0] = 1'b1; wb_r[0] = 5'd7; wb_t[0] = 4'd0; wb_d[0] = 32'hBEEF;
    run_cycle("t6b");
    idle();
    rd_idx[1] = 5'd7;
    #1 expect_port("t6_r7", 1, 32'hBEEF, 1'b1);
    #1 rst = 1'b0;
    #1 expect_port("t6_rst", 1, 32'h0, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        idle();
        for (int k = 0; k < NR; k++) rd_idx[k] = pick_reg();
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < NR; k++) expect_port("rand_rst", k, 32'h0, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
      end
      random_inputs();
      run_cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
